// File: rtl/egg_timer_pkg.sv
// Shared display constants for the egg timer: active-low segment patterns
// ({g,f,e,d,c,b,a}), the all-off anode value and the scan digit index type.
package egg_timer_pkg;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  localparam logic [3:0] ANODE_OFF = 4'b1111;

  typedef logic [1:0] digit_idx_t;

  // One-hot-low anode select for a digit position.
  function automatic logic [3:0] anode_for(input digit_idx_t idx);
    logic [3:0] onehot;
    onehot = 4'b0001 << idx;
    return ~onehot;
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes show a dash.
module bcd_to_seg
  import egg_timer_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/egg_display_scan.sv
// Multiplexed 4-digit common-anode display driver for the egg timer (MM:SS),
// with per-frame snapshot, leading-zero blanking, colon and done-blink.
module egg_display_scan
  import egg_timer_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] second_ones,
  input  logic [3:0] second_tens,
  input  logic [3:0] minute_ones,
  input  logic [3:0] minute_tens,
  input  logic       blank_lead,
  input  logic       blink_en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;

  logic [CW-1:0]   count;
  logic            tick;
  digit_idx_t      idx;
  logic [3:0][3:0] snap;
  logic [BW-1:0]   blink_cnt;
  logic            blink_phase;
  logic [3:0]      cur_digit;
  logic [6:0]      cur_seg;
  logic            blank;
  logic [3:0]      an_next;
  logic [6:0]      seg_next;
  logic            dp_next;

  assign tick = (count == CW'(REFRESH_DIV - 1));

  // Prescaler, digit index and the once-per-frame snapshot; the snapshot is
  // taken on the 3->0 wrap so a whole frame always shows one consistent time.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count      <= '0;
      idx        <= '0;
      snap       <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= tick && (idx == 2'd3);
      if (tick) begin
        count <= '0;
        idx   <= idx + 2'd1;
        if (idx == 2'd3) begin
          snap <= {minute_tens, minute_ones, second_tens, second_ones};
        end
      end else begin
        count <= count + CW'(1);
      end
    end
  end

  // Blink half-period counter; held clear while blinking is disabled so the
  // display relights at once and every blink episode starts lit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (!blink_en) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_tick) begin
      if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  assign cur_digit = snap[idx];

  bcd_to_seg u_dec (
    .bcd (cur_digit),
    .seg (cur_seg)
  );

  always_comb begin
    blank    = (blink_en && blink_phase) ||
               ((idx == 2'd3) && blank_lead && (snap[3] == 4'd0));
    an_next  = blank ? ANODE_OFF : anode_for(idx);
    seg_next = blank ? SEG_OFF : cur_seg;
    dp_next  = !((idx == 2'd2) && !blank);
  end

  // Registered pin drivers: one cycle behind idx, so each digit is lit for
  // exactly REFRESH_DIV cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an  <= ANODE_OFF;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else begin
      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_egg_display_scan.sv
// Self-checking bench for egg_display_scan: frame-arithmetic reference model
// compared every cycle, plus hand-computed literal checkpoints.
module tb_egg_display_scan;

  localparam int R  = 4;
  localparam int BF = 2;
  localparam int FRAME = 4 * R;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] second_ones, second_tens, minute_ones, minute_tens;
  logic       blank_lead, blink_en;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp, frame_tick;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  egg_display_scan #(.REFRESH_DIV(R), .BLINK_FRAMES(BF)) dut (
    .clk         (clk),
    .reset       (reset),
    .second_ones (second_ones),
    .second_tens (second_tens),
    .minute_ones (minute_ones),
    .minute_tens (minute_tens),
    .blank_lead  (blank_lead),
    .blink_en    (blink_en),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_table [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

  // Reference model: position in the scan follows from the edge count since
  // reset; the blink phase follows from frames counted while blink_en is high.
  int         edges;
  int         frames_on;
  logic [3:0] m_snap [4];
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp, exp_ft;
  int         m_idx;
  bit         m_phase, m_blank, m_ft_prev;
  logic [3:0] m_onehot;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      edges     = 0;
      frames_on = 0;
      for (int i = 0; i < 4; i++) m_snap[i] = 4'd0;
      exp_an    = 4'hF;
      exp_seg   = 7'h7F;
      exp_dp    = 1'b1;
      exp_ft    = 1'b0;
    end else begin
      m_idx     = (edges / R) % 4;
      m_phase   = ((frames_on / BF) % 2) == 1;
      m_ft_prev = exp_ft;
      m_blank   = (blink_en && m_phase) ||
                  (m_idx == 3 && blank_lead && m_snap[3] == 4'd0);
      m_onehot  = 4'b0001 << m_idx;
      exp_an    = m_blank ? 4'hF : ~m_onehot;
      exp_seg   = m_blank ? 7'h7F : seg_table[m_snap[m_idx]];
      exp_dp    = !(m_idx == 2 && !m_blank);
      exp_ft    = (edges % FRAME) == FRAME - 1;
      if (exp_ft) begin
        m_snap[0] = second_ones;
        m_snap[1] = second_tens;
        m_snap[2] = minute_ones;
        m_snap[3] = minute_tens;
      end
      if (!blink_en) frames_on = 0;
      else if (m_ft_prev) frames_on = frames_on + 1;
      edges = edges + 1;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      checks++;
      if ({an, seg, dp, frame_tick} !== {exp_an, exp_seg, exp_dp, exp_ft}) begin
        errors++;
        $display("[TB] FAIL model t=%0t got an=%b seg=%b dp=%b ft=%b want an=%b seg=%b dp=%b ft=%b",
                 $time, an, seg, dp, frame_tick, exp_an, exp_seg, exp_dp, exp_ft);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_output(input string name, input logic [3:0] e_an,
                              input logic [6:0] e_seg, input logic e_dp, input logic e_ft);
    checks++;
    if ({an, seg, dp, frame_tick} !== {e_an, e_seg, e_dp, e_ft}) begin
      errors++;
      $display("[TB] FAIL %s got an=%b seg=%b dp=%b ft=%b want an=%b seg=%b dp=%b ft=%b",
               name, an, seg, dp, frame_tick, e_an, e_seg, e_dp, e_ft);
    end
  endtask

  task automatic wait_frame(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2 * FRAME && !seen; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL %s got no frame_tick want frame_tick within %0d cycles", name, 2 * FRAME);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] s1, input logic [3:0] s10,
                                input logic [3:0] m1, input logic [3:0] m10);
    second_ones = s1;
    second_tens = s10;
    minute_ones = m1;
    minute_tens = m10;
  endtask

  initial begin
    reset      = 1'b0;
    blank_lead = 1'b0;
    blink_en   = 1'b0;
    apply_stimulus(4'd1, 4'd2, 4'd3, 4'd4);
    step(3);
    check_en = 1'b1;
    check_output("reset_state", 4'hF, 7'h7F, 1'b1, 1'b0);
    reset = 1'b1;

    step(1); check_output("first_idx0", 4'b1110, 7'h40, 1'b1, 1'b0);
    step(4); check_output("first_idx1", 4'b1101, 7'h40, 1'b1, 1'b0);
    step(4); check_output("first_idx2", 4'b1011, 7'h40, 1'b0, 1'b0);
    step(4); check_output("first_idx3", 4'b0111, 7'h40, 1'b1, 1'b0);
    wait_frame("first_frame");
    step(1); check_output("snap_idx0", 4'b1110, 7'h79, 1'b1, 1'b0);
    step(4); check_output("snap_idx1", 4'b1101, 7'h24, 1'b1, 1'b0);
    second_ones = 4'd9;
    step(4); check_output("snap_idx2", 4'b1011, 7'h30, 1'b0, 1'b0);
    step(4); check_output("snap_idx3", 4'b0111, 7'h19, 1'b1, 1'b0);
    wait_frame("second_frame");
    step(1); check_output("new_ones", 4'b1110, 7'h10, 1'b1, 1'b0);

    minute_tens = 4'd0;
    blank_lead  = 1'b1;
    wait_frame("blank_frame");
    step(13); check_output("blank_tens", 4'hF, 7'h7F, 1'b1, 1'b0);
    blank_lead = 1'b0;
    step(1); check_output("tens_shown", 4'b0111, 7'h40, 1'b1, 1'b0);
    blank_lead  = 1'b1;
    minute_ones = 4'd0;
    wait_frame("ones_frame");
    step(9); check_output("ones_zero", 4'b1011, 7'h40, 1'b0, 1'b0);

    second_tens = 4'hC;
    wait_frame("dash_frame");
    step(5); check_output("dash", 4'b1101, 7'h3F, 1'b1, 1'b0);

    wait_frame("blink_start");
    blink_en = 1'b1;
    wait_frame("blink_f1");
    step(2); check_output("blink_dark", 4'hF, 7'h7F, 1'b1, 1'b0);
    wait_frame("blink_f2");
    wait_frame("blink_f3");
    step(2); check_output("blink_lit", 4'b1110, 7'h10, 1'b1, 1'b0);
    wait_frame("blink_f4");
    wait_frame("blink_f5");
    step(2); check_output("blink_dark2", 4'hF, 7'h7F, 1'b1, 1'b0);
    blink_en = 1'b0;
    step(1); check_output("blink_off", 4'b1110, 7'h10, 1'b1, 1'b0);

    blank_lead = 1'b0;
    wait_frame("pre_reset");
    step(9); check_output("pre_reset_idx2", 4'b1011, 7'h40, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1 check_output("async_reset", 4'hF, 7'h7F, 1'b1, 1'b0);
    step(1);
    reset = 1'b1;
    step(1); check_output("restart", 4'b1110, 7'h40, 1'b1, 1'b0);
    step(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/egg_display_scan.md
Name: egg_display_scan

Overview:
- Consumer end of the timer's BCD digit interface. Takes the four countdown/load digits (MM:SS) and drives a 4-digit, common-anode, multiplexed 7-segment display.
- Time-multiplexes the digits at a programmable refresh rate and latches a tear-free snapshot once per frame.
- Blanks the leading zero, lights the colon, and blinks the whole display when the timer signals done.
- Sits between the countdown/load datapath and the board I/O pins.

Parameters:
- REFRESH_DIV, 100000, clk cycles each digit stays lit (min 2).
- BLINK_FRAMES, 64, scan frames per blink half-period (min 1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- second_ones  in  4  BCD seconds units
- second_tens  in  4  BCD seconds tens
- minute_ones  in  4  BCD minutes units
- minute_tens  in  4  BCD minutes tens
- blank_lead  in  1  1 = blank minute_tens when it is 0
- blink_en  in  1  1 = blink the whole display (timer expired)
- an  out  4  digit anodes, active-low; an[0] = second_ones … an[3] = minute_tens
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low; used as the colon
- frame_tick  out  1  one-cycle pulse at each frame start

Behaviour:
- Reset (reset=0, async) forces:
  - an=4'b1111, seg=7'b1111111, dp=1, frame_tick=0
  - prescaler=0, digit index idx=0, snapshot digits=0
  - blink frame counter=0, blink_phase=0
- Prescaler:
  - Counts 0..REFRESH_DIV-1; tick=1 when count==REFRESH_DIV-1, then count wraps to 0.
  - On tick, idx advances 0→1→2→3→0.
- Snapshot: on the tick where idx goes 3→0, all four input digits are registered into the snapshot. Inputs are otherwise ignored. Until the first wrap, the snapshot holds 0.
- frame_tick: registered; high for exactly the one cycle after the 3→0 tick.
- Blink:
  - On each frame_tick the blink counter increments.
  - When it reaches BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
  - blink_en=0 clears the counter and blink_phase synchronously, so the display is lit immediately.
- Outputs: an/seg/dp are registered, decoded from the current idx and snapshot. They lag idx by one cycle, so each digit is lit for exactly REFRESH_DIV cycles.
  - an = one-hot-low at position idx.
  - Forced to 4'b1111 when blink_en=1 and blink_phase=1.
  - Forced to 4'b1111 when idx==3, blank_lead=1 and snapshot minute_tens==0. minute_ones is never blanked.
  - dp=0 only when idx==2 (colon after minutes) and the digit is not blanked; otherwise 1.
- Decode (active-low, {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - codes 10–15 show a dash = 0111111
- Simultaneous events: blink blanking takes priority over the digit pattern. A snapshot and a blink toggle in the same cycle are both applied.
- Reset mid-frame: outputs return to reset values immediately. Scanning restarts at idx 0 with snapshot 0.

Decomposition:
- Shared package (egg_timer_pkg):
  - segment-pattern constants SEG_0..SEG_9, SEG_DASH, SEG_OFF
  - ANODE_OFF
  - digit index type (2-bit)
- One sub-module, bcd_to_seg: purely combinational 4-bit → 7-bit decoder, instantiated once on the muxed snapshot digit.

Test Plan (REFRESH_DIV=4, BLINK_FRAMES=2):
- Reset held low then released, inputs 1,2,3,4 (MM:SS=43:21):
  - First frame shows 0s on an 1110,1101,1011,0111, each for 4 cycles.
  - After the first frame_tick: an=1110/seg=1111001, an=1101/seg=0100100, an=1011/seg=0110000/dp=0, an=0111/seg=0011001.
- Inputs change mid-frame (second_ones 1→9 while idx=1): displayed value stays 1 until after the next frame_tick, then becomes 0010000.
- minute_tens=0, blank_lead=1: an stays 1111 during the idx=3 slot. With blank_lead=0, seg=1000000 is shown. minute_ones=0 is always shown.
- blink_en=1: an=1111 for frames where blink_phase=1, alternating every 2 frames (32 cycles lit / 32 dark). Dropping blink_en relights on the next cycle.
- second_tens=4'hC: that digit shows seg=0111111.
- reset asserted during idx=2: an=1111, seg=1111111, dp=1 in the same cycle with no clk edge. After release, scanning restarts at an=1110.
